// File: rtl/dram_pkg.sv
// Shared constants, decode-result type and address decoder for the dram_resp data-port responder.
package dram_pkg;

    localparam logic [31:0] ADDR_BASE_DEF   = 32'h8000_0000;
    localparam int          DEPTH_WORDS_DEF = 16384;
    localparam logic [31:0] TIMER_ADDR_DEF  = 32'hA000_0048;

    // Offsets of the two timer halves from the timer base address
    localparam logic [31:0] TLO_OFS = 32'd0;
    localparam logic [31:0] THI_OFS = 32'd4;

    typedef enum logic [1:0] {
        HIT_RAM,
        HIT_TLO,
        HIT_THI,
        MISS
    } dec_e;

    // span is the array size in bytes; 33 bits so a full 4 GiB window cannot overflow
    function automatic dec_e decode_addr(
        input logic [31:0] word_addr,
        input logic [31:0] base,
        input logic [32:0] span,
        input logic [31:0] timer_addr
    );
        logic [32:0] ofs;
        dec_e        res;
        ofs = {1'b0, word_addr} - {1'b0, base};
        if ((word_addr >= base) && (ofs < span)) begin
            res = HIT_RAM;
        end else if (word_addr == timer_addr + TLO_OFS) begin
            res = HIT_TLO;
        end else if (word_addr == timer_addr + THI_OFS) begin
            res = HIT_THI;
        end else begin
            res = MISS;
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 64-bit cycle timer with byte-masked software writes and a high-word
// snapshot taken whenever the low word is loaded.
module mmio_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        lo_load,
    input  logic        lo_store,
    input  logic        hi_store,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] timer_lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] timer_reg;
    logic [63:0] timer_next;
    logic [63:0] timer_inc;
    logic [31:0] hi_shadow_reg;
    logic [31:0] lo_merge;
    logic [31:0] hi_merge;

    assign timer_inc = timer_reg + 64'd1;

    // Unwritten lanes of the stored half hold their value instead of incrementing
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lo_merge[8*gi +: 8] = wmask[gi] ? wdata[8*gi +: 8] : timer_reg[8*gi +: 8];
            assign hi_merge[8*gi +: 8] = wmask[gi] ? wdata[8*gi +: 8] : timer_reg[32+8*gi +: 8];
        end
    endgenerate

    always_comb begin
        timer_next = timer_inc;
        if (lo_store) begin
            timer_next[31:0] = lo_merge;
        end
        if (hi_store) begin
            timer_next[63:32] = hi_merge;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg     <= '0;
            hi_shadow_reg <= '0;
        end else begin
            timer_reg <= timer_next;
            if (lo_load) begin
                hi_shadow_reg <= timer_reg[63:32];
            end
        end
    end

    assign timer_lo  = timer_reg[31:0];
    assign hi_shadow = hi_shadow_reg;

endmodule

// File: rtl/dram_resp.sv
// Data-port responder: word RAM with byte-masked writes, sticky out-of-range fault record,
// and an optional memory-mapped cycle timer present when DRAM_TIMER_EN is defined.
module dram_resp
    import dram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] TIMER_ADDR  = TIMER_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dram_en,
    input  logic        dram_wen,
    input  logic [31:0] dram_addr,
    input  logic [31:0] dram_wdata,
    input  logic [3:0]  dram_wmask,
    output logic [31:0] dram_rdata,
    output logic        dram_fault,
    output logic [31:0] fault_addr
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]      word_addr;
    dec_e             dec;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_word;
    logic             ram_wr;
    logic             miss;
    logic             fault_reg;
    logic [31:0]      fault_addr_reg;

    assign word_addr = {dram_addr[31:2], 2'b00};

    always_comb begin
        dec = decode_addr(word_addr, ADDR_BASE, SPAN, TIMER_ADDR);
`ifndef DRAM_TIMER_EN
        if ((dec == HIT_TLO) || (dec == HIT_THI)) begin
            dec = MISS;
        end
`endif
    end

    assign ram_idx = IDX_W'((word_addr - ADDR_BASE) >> 2);
    assign ram_wr  = dram_en && dram_wen && (dec == HIT_RAM);
    assign miss    = dram_en && (dec == MISS);

    // One byte-wide array per lane; reset only gates the write so a store at a
    // reset edge is dropped, the contents themselves are never cleared.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk or negedge rst) begin
                if (rst && ram_wr && dram_wmask[gi]) begin
                    lane_mem[ram_idx] <= dram_wdata[8*gi +: 8];
                end
            end

            assign ram_word[8*gi +: 8] = lane_mem[ram_idx];
        end
    endgenerate

`ifdef DRAM_TIMER_EN
    logic [31:0] timer_lo;
    logic [31:0] hi_shadow;
    logic        lo_load;
    logic        lo_store;
    logic        hi_store;

    // A zero-mask store is a pure no-op, so it must not stall the written half
    assign lo_load  = dram_en && !dram_wen && (dec == HIT_TLO);
    assign lo_store = dram_en && dram_wen && (dec == HIT_TLO) && (|dram_wmask);
    assign hi_store = dram_en && dram_wen && (dec == HIT_THI) && (|dram_wmask);

    mmio_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .lo_load   (lo_load),
        .lo_store  (lo_store),
        .hi_store  (hi_store),
        .wdata     (dram_wdata),
        .wmask     (dram_wmask),
        .timer_lo  (timer_lo),
        .hi_shadow (hi_shadow)
    );
`endif

    always_comb begin
        dram_rdata = '0;
        if (dram_en && !dram_wen) begin
            case (dec)
                HIT_RAM: dram_rdata = ram_word;
`ifdef DRAM_TIMER_EN
                HIT_TLO: dram_rdata = timer_lo;
                HIT_THI: dram_rdata = hi_shadow;
`endif
                default: dram_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_reg      <= 1'b0;
            fault_addr_reg <= '0;
        end else if (miss && !fault_reg) begin
            fault_reg      <= 1'b1;
            fault_addr_reg <= dram_addr;
        end
    end

    assign dram_fault = fault_reg;
    assign fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_dram_resp.sv
// Directed self-checking bench for dram_resp; timer checks follow DRAM_TIMER_EN.
module tb_dram_resp;

    localparam logic [31:0] TA = 32'hA000_0048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dram_en = 1'b0;
    logic        dram_wen = 1'b0;
    logic [31:0] dram_addr = '0;
    logic [31:0] dram_wdata = '0;
    logic [3:0]  dram_wmask = '0;
    logic [31:0] dram_rdata;
    logic        dram_fault;
    logic [31:0] fault_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd;

    dram_resp dut (
        .clk        (clk),
        .rst        (rst),
        .dram_en    (dram_en),
        .dram_wen   (dram_wen),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_wmask (dram_wmask),
        .dram_rdata (dram_rdata),
        .dram_fault (dram_fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, output logic [31:0] rdv);
        @(negedge clk);
        dram_en    = 1'b1;
        dram_wen   = wen;
        dram_addr  = addr;
        dram_wdata = wdata;
        dram_wmask = mask;
        #1;
        rdv = dram_rdata;
        $display("txn %s addr=%h wdata=%h mask=%b rdata=%h fault=%b fault_addr=%h",
                 wen ? "ST" : "LD", addr, wdata, mask, rdv, dram_fault, fault_addr);
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] rdv);
        access(1'b0, addr, 32'h0, 4'h0, rdv);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        logic [31:0] dummy;
        access(1'b1, addr, wdata, mask, dummy);
    endtask

    task automatic idle();
        @(negedge clk);
        dram_en    = 1'b0;
        dram_wen   = 1'b0;
        dram_wmask = 4'h0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_rdata", dram_rdata, 32'h0);
        check_val("rst_fault", 32'(dram_fault), 32'h0);
        check_val("rst_faddr", fault_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

`ifdef DRAM_TIMER_EN
        repeat (5) @(posedge clk);
        load(TA, rd);             check_val("tlo_cycle5", rd, 32'd5);
        store(TA, 32'hFFFF_FFFF, 4'hF);
        load(TA, rd);             check_val("tlo_preset", rd, 32'hFFFF_FFFF);
        load(TA, rd);             check_val("tlo_wrap", rd, 32'h0);
        load(TA + 4, rd);         check_val("thi_carry", rd, 32'd1);

        store(TA + 4, 32'h0, 4'hF);
        store(TA, 32'hFFFF_FFFE, 4'hF);
        load(TA, rd);             check_val("snap_lo", rd, 32'hFFFF_FFFE);
        idle();
        idle();
        load(TA + 4, rd);         check_val("snap_hi_shadow", rd, 32'h0);
        load(TA, rd);             check_val("snap_lo_live", rd, 32'd2);
        load(TA + 4, rd);         check_val("snap_hi_live", rd, 32'd1);

        store(TA + 4, 32'hFFFF_FFFF, 4'hF);
        store(TA, 32'hFFFF_FFFF, 4'hF);
        load(TA, rd);             check_val("max_lo", rd, 32'hFFFF_FFFF);
        load(TA + 4, rd);         check_val("max_hi", rd, 32'hFFFF_FFFF);
        load(TA, rd);             check_val("wrap64_lo", rd, 32'd1);
        load(TA + 4, rd);         check_val("wrap64_hi", rd, 32'h0);
        idle();
        check_val("timer_nofault", 32'(dram_fault), 32'h0);
`endif

        store(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
        store(32'h8000_0010, 32'h0000_5500, 4'b0010);
        load(32'h8000_0010, rd);  check_val("ram_merge", rd, 32'hDEAD_55EF);
        load(32'h8000_0013, rd);  check_val("ram_lowbits", rd, 32'hDEAD_55EF);
        store(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
        load(32'h8000_0010, rd);  check_val("ram_mask0", rd, 32'hDEAD_55EF);
        store(32'h8000_FFFC, 32'h1122_3344, 4'hF);
        store(32'h8000_0000, 32'h0000_0000, 4'hF);
        store(32'h8000_0000, 32'hA5A5_A5A5, 4'b1001);
        load(32'h8000_FFFC, rd);  check_val("ram_last", rd, 32'h1122_3344);
        load(32'h8000_0000, rd);  check_val("ram_first", rd, 32'hA500_00A5);
        idle();
        check_val("ram_nofault", 32'(dram_fault), 32'h0);

`ifndef DRAM_TIMER_EN
        load(TA, rd);             check_val("notimer_rd", rd, 32'h0);
        idle();
        check_val("notimer_fault", 32'(dram_fault), 32'h1);
        check_val("notimer_faddr", fault_addr, TA);
        store(TA + 4, 32'h1234_5678, 4'hF);
        load(TA + 4, rd);         check_val("notimer_hi_rd", rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dram_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("notimer_fault_clr", 32'(dram_fault), 32'h0);
`endif

        load(32'h8001_0000, rd);  check_val("oor_rdata", rd, 32'h0);
        idle();
        check_val("oor_fault", 32'(dram_fault), 32'h1);
        check_val("oor_faddr", fault_addr, 32'h8001_0000);
        load(32'h0000_0000, rd);  check_val("miss0_rdata", rd, 32'h0);
        load(32'h7FFF_FFFC, rd);  check_val("below_rdata", rd, 32'h0);
        idle();
        check_val("sticky_faddr", fault_addr, 32'h8001_0000);
        check_val("sticky_fault", 32'(dram_fault), 32'h1);

        store(32'h8000_0020, 32'h1234_5678, 4'hF);
        load(32'h8000_0020, rd);  check_val("pre_rst_word", rd, 32'h1234_5678);
        @(negedge clk);
        rst        = 1'b0;
        dram_en    = 1'b1;
        dram_wen   = 1'b1;
        dram_addr  = 32'h8000_0020;
        dram_wdata = 32'hAAAA_AAAA;
        dram_wmask = 4'hF;
        #1;
        $display("txn ST(rst) addr=%h wdata=%h mask=%b rdata=%h fault=%b fault_addr=%h",
                 dram_addr, dram_wdata, dram_wmask, dram_rdata, dram_fault, fault_addr);
        check_val("rst_mid_fault", 32'(dram_fault), 32'h0);
        check_val("rst_mid_faddr", fault_addr, 32'h0);
        @(negedge clk);
        rst      = 1'b1;
        dram_en  = 1'b0;
        dram_wen = 1'b0;
        #1;
        check_val("rst_mid_rdata", dram_rdata, 32'h0);
`ifdef DRAM_TIMER_EN
        load(TA, rd);             check_val("rst_timer_lo", rd, 32'd1);
        load(TA + 4, rd);         check_val("rst_timer_hi", rd, 32'h0);
`endif
        load(32'h8000_0020, rd);  check_val("rst_store_drop", rd, 32'h1234_5678);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dram_resp.md
# dram_resp

Data-memory responder on the far side of the core's `dram_*` initiator port. It decodes each access and serves a word array with byte-masked synchronous writes and same-cycle combinational reads. It also provides an optional memory-mapped 64-bit cycle timer and captures out-of-range accesses into a sticky fault record. It sits beside the CPU in the top-level SoC wrapper and is the sole target of the data port.

## Interface
- `ADDR_BASE`, 32'h8000_0000, byte address of word 0 of the array.
- `DEPTH_WORDS`, 16384, array depth in 32-bit words; power of two.
- `TIMER_ADDR`, 32'hA000_0048, byte address of timer low word; high word at `TIMER_ADDR+4`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `dram_en`  in  1  access valid this cycle.
- `dram_wen`  in  1  1 = store, 0 = load; ignored when `dram_en`=0.
- `dram_addr`  in  32  byte address; bits [1:0] ignored for decode.
- `dram_wdata`  in  32  store data, already lane-aligned.
- `dram_wmask`  in  4  byte-lane enables, bit i → `dram_wdata[8i+7:8i]`.
- `dram_rdata`  out  32  load data, combinational, full aligned word.
- `dram_fault`  out  1  sticky: an out-of-range access occurred.
- `fault_addr`  out  32  `dram_addr` of the first faulting access.

## Operation
- Decode on `word_addr = dram_addr & ~3`:
  - RAM hit: `ADDR_BASE <= word_addr < ADDR_BASE + 4*DEPTH_WORDS`. Index is `(word_addr - ADDR_BASE) >> 2`, with log2(`DEPTH_WORDS`) bits.
  - TLO: `word_addr == TIMER_ADDR`.
  - THI: `word_addr == TIMER_ADDR+4`.
  - Anything else is a miss.
- Load (`en`=1, `wen`=0):
  - RAM hit returns the array word.
  - TLO returns `timer[31:0]`.
  - THI returns `hi_shadow`.
  - A miss returns 0.
  - `dram_rdata` = 0 whenever `en`=0.
- Store (`en`=1, `wen`=1):
  - RAM hit writes each masked byte lane at the edge.
  - TLO/THI loads the masked bytes into the corresponding timer half.
  - A miss drops the write.
  - `wmask`=0 is a legal no-op and not a fault.
- Timer: 64-bit, +1 every cycle out of reset.
  - A timer store in the same cycle overrides the increment for the written half. The other half still takes its incremented value, including carry.
  - Wraps from 2^64-1 to 0 silently.
- Hi snapshot: a load of TLO copies the current `timer[63:32]` into `hi_shadow` at that edge. Software reads low, then high, and gets a coherent 64-bit value.
- Fault: on any miss with `en`=1 and `dram_fault`=0:
  - set `dram_fault`;
  - capture `fault_addr`.
  - Later misses do not overwrite it. Only reset clears it.

## Timing
- Read latency 0: `dram_rdata` is valid in the same cycle as `dram_en`/`dram_addr`.
- Write visible to a load on the cycle after the store edge.
- Load and store to the same address in the same cycle is impossible (one port). A load in cycle N+1 after a store in cycle N returns the new data.
- Reset values:
  - `dram_rdata` = 0 (en low);
  - `dram_fault` = 0;
  - `fault_addr` = 0;
  - `timer` = 0;
  - `hi_shadow` = 0.
- RAM contents are not reset.
- Reset asserted mid-cycle: all registers clear immediately. A store whose edge coincides with `rst` low is discarded. The first increment occurs on the first edge after `rst` rises, so the timer reads 1 one cycle after deassert.
- No back-pressure and no ready signal: every access completes in its cycle.

## Configuration
- `DRAM_TIMER_EN` defined: timer, `hi_shadow` and TLO/THI decode are present as above.
- Undefined:
  - no timer logic;
  - TLO/THI decode as misses: loads return 0, stores are dropped, `dram_fault` is set.

## Structure
- `dram_pkg`:
  - default `ADDR_BASE`, `TIMER_ADDR`;
  - TLO/THI offsets (0, 4);
  - decode-result enum {HIT_RAM, HIT_TLO, HIT_THI, MISS}.
- One sub-module, `mmio_timer`:
  - holds the 64-bit counter and `hi_shadow`;
  - inputs: load-low strobe, store strobes, masks;
  - instantiated only under `DRAM_TIMER_EN`.

## Test plan
- Store 32'hDEADBEEF mask 4'b1111 at 32'h8000_0010, then store 32'h0000_5500 mask 4'b0010 → load returns 32'hDEAD55EF next cycle.
- Load at 32'h8001_0000 (one past a 64 KiB array) → `dram_rdata`=0, `dram_fault`=1, `fault_addr`=32'h8001_0000. A later miss at 32'h0 leaves `fault_addr` unchanged.
- Timer (macro on): after reset deassert, load TLO at cycle 5 → 5. Store 32'hFFFF_FFFF to TLO, then load TLO/THI → low wraps to 0 within two cycles, and THI shows 1 after the next TLO load.
- Hi snapshot: preload timer to 32'h0000_0000_FFFF_FFFE. Load TLO → 32'hFFFF_FFFE. Three cycles later load THI → 0 (shadow), not the live value 1.
- Assert `rst` low during a store to 32'h8000_0020 → word unchanged; all outputs and counters read 0.
- Macro off: load at `TIMER_ADDR` → 0 and `dram_fault`=1.
